// File: rtl/svfloat_pack_arbiter.sv
// Arbitrates N float-pack requests onto one shared svfloat_packer through a two-stage pipeline.
// Define SVFLOAT_PACK_ARB_ROUNDROBIN_EN for round-robin grants; the default build uses fixed priority.

package svfloat;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32;

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] man;
  } float64;

endpackage

// Packs sign/unbiased exponent/fixed-point mantissa into an IEEE-style float.
// Rounds to nearest-even; results below the normal range flush to signed zero.
module svfloat_packer #(
  parameter type float  = svfloat::float32,
  parameter int  ewidth = 9,
  parameter int  width  = 46,
  parameter int  frac   = 23
) (
  input  logic                     is_inf,
  input  logic                     is_nan,
  input  logic                     is_zero,
  input  logic                     sign,
  input  logic signed [ewidth-1:0] exp,
  input  logic [width-1:0]         man,
  output float                     res
);

  localparam int fw   = $bits(float);
  localparam int fe   = (fw == 16) ? 5 : (fw == 64) ? 11 : 8;
  localparam int fm   = fw - 1 - fe;
  localparam int bias = (1 << (fe - 1)) - 1;
  localparam int emax = 2 * bias;

  int               lead;
  logic [width-2:0] norm;
  logic [fm-1:0]    mant;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [fm:0]      mant_r;
  int               e_b;
  logic [fw-1:0]    bits;

  // NOTE: every variable is written on every path through this block, otherwise a latch is inferred.
  always_comb begin
    lead = 0;
    for (int i = 0; i < width; i++)
      if (man[i]) lead = i;

    // Leading one shifted out to the hidden-bit position; what remains is fraction, guard, sticky.
    norm     = (width - 1)'(man << (width - 1 - lead));
    mant     = norm[width-2 -: fm];
    guard    = norm[width-2-fm];
    sticky   = |norm[width-3-fm:0];
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{fm{1'b0}}, round_up};
    e_b      = int'(exp) + lead - frac + bias + int'(mant_r[fm]);

    if (is_nan)
      bits = {sign, {fe{1'b1}}, 1'b1, {(fm-1){1'b0}}};
    else if (is_inf)
      bits = {sign, {fe{1'b1}}, {fm{1'b0}}};
    else if (is_zero || man == '0)
      bits = {sign, {(fw-1){1'b0}}};
    else if (e_b > emax)
      bits = {sign, {fe{1'b1}}, {fm{1'b0}}};
    else if (e_b < 1)
      bits = {sign, {(fw-1){1'b0}}};
    else
      bits = {sign, e_b[fe-1:0], mant_r[fm-1:0]};
  end

  assign res = bits;

endmodule

module svfloat_pack_arbiter #(
  parameter type float  = svfloat::float32,
  parameter int  ewidth = 9,
  parameter int  width  = 46,
  parameter int  frac   = 23,
  parameter int  ports  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ports-1:0]             req_valid,
  output logic [ports-1:0]             req_ready,
  input  logic [ports-1:0]             req_is_inf,
  input  logic [ports-1:0]             req_is_nan,
  input  logic [ports-1:0]             req_is_zero,
  input  logic [ports-1:0]             req_sign,
  input  logic [ports-1:0][ewidth-1:0] req_exp,
  input  logic [ports-1:0][width-1:0]  req_man,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(ports)-1:0]     res_id,
  output float                         res
);

  localparam int idw = $clog2(ports);

  logic                     v1;
  logic                     v2;
  logic                     adv1;
  logic                     adv2;
  logic                     load2;
  logic                     xfer;
  logic                     grant_any;
  logic [idw-1:0]           grant_id;

  logic [idw-1:0]           id1;
  logic                     s1_inf;
  logic                     s1_nan;
  logic                     s1_zero;
  logic                     s1_sign;
  logic signed [ewidth-1:0] s1_exp;
  logic [width-1:0]         s1_man;

  float                     pack_res;
  float                     res_q;
  logic [idw-1:0]           id2;

  assign adv2  = v2 && res_ready;
  assign load2 = v1 && (!v2 || adv2);
  assign adv1  = !v1 || load2;

`ifdef SVFLOAT_PACK_ARB_ROUNDROBIN_EN
  localparam logic [idw:0] ports_w = (idw + 1)'(ports);

  logic [idw-1:0]   ptr;
  logic [ports-1:0] rot;
  logic [idw-1:0]   off;
  logic [idw:0]     sum;

  // Rotate so the pointer's requester sits at bit 0, pick the lowest set bit, then rotate back.
  always_comb begin
    rot       = ports'({req_valid, req_valid} >> ptr);
    grant_any = 1'b0;
    off       = '0;
    for (int k = ports - 1; k >= 0; k--)
      if (rot[k]) begin
        grant_any = 1'b1;
        off       = k[idw-1:0];
      end
    sum      = {1'b0, ptr} + {1'b0, off};
    grant_id = (sum >= ports_w) ? idw'(sum - ports_w) : idw'(sum);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (xfer)
      ptr <= (grant_id == idw'(ports - 1)) ? '0 : grant_id + 1'b1;
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = ports - 1; k >= 0; k--)
      if (req_valid[k]) begin
        grant_any = 1'b1;
        grant_id  = k[idw-1:0];
      end
  end
`endif

  // Gating with rst_n keeps the handshake quiet while the synchronous reset is held.
  assign xfer      = grant_any && adv1 && rst_n;
  assign req_ready = xfer ? (ports'(1) << grant_id) : '0;

  // NOTE: payload flops carry no reset; v1 alone decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (xfer) begin
      id1     <= grant_id;
      s1_inf  <= req_is_inf[grant_id];
      s1_nan  <= req_is_nan[grant_id];
      s1_zero <= req_is_zero[grant_id];
      s1_sign <= req_sign[grant_id];
      s1_exp  <= req_exp[grant_id];
      s1_man  <= req_man[grant_id];
    end
  end

  svfloat_packer #(
    .float  (float),
    .ewidth (ewidth),
    .width  (width),
    .frac   (frac)
  ) u_packer (
    .is_inf  (s1_inf),
    .is_nan  (s1_nan),
    .is_zero (s1_zero),
    .sign    (s1_sign),
    .exp     (s1_exp),
    .man     (s1_man),
    .res     (pack_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      res_q <= '0;
      id2   <= '0;
    end else begin
      if (xfer)
        v1 <= 1'b1;
      else if (load2)
        v1 <= 1'b0;

      if (load2) begin
        v2    <= 1'b1;
        res_q <= pack_res;
        id2   <= id1;
      end else if (adv2) begin
        v2 <= 1'b0;
      end
    end
  end

  assign res_valid = v2 && rst_n;
  assign res_id    = id2;
  assign res       = res_q;

endmodule

// File: tb/tb_svfloat_pack_arbiter.sv
// Directed self-checking bench for svfloat_pack_arbiter (default parameters, float32 output).
// Expected grant order follows SVFLOAT_PACK_ARB_ROUNDROBIN_EN when the bench is built with it.

module tb_svfloat_pack_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0]       req_is_inf;
  logic [3:0]       req_is_nan;
  logic [3:0]       req_is_zero;
  logic [3:0]       req_sign;
  logic [3:0][8:0]  req_exp;
  logic [3:0][45:0] req_man;
  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_id;
  logic [31:0]      res;

  int errors = 0;
  int checks = 0;

  localparam logic [45:0] ONE = 46'd1 << 23;

  svfloat_pack_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_is_inf  (req_is_inf),
    .req_is_nan  (req_is_nan),
    .req_is_zero (req_is_zero),
    .req_sign    (req_sign),
    .req_exp     (req_exp),
    .req_man     (req_man),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res         (res)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

  task automatic clear_reqs();
    req_is_inf  = '0;
    req_is_nan  = '0;
    req_is_zero = '0;
    req_sign    = '0;
    req_exp     = '0;
    req_man     = '0;
  endtask

  task automatic set_req(input int i, input logic nan, input logic inf, input logic zero,
                         input logic sgn, input logic [8:0] e, input logic [45:0] m);
    req_is_nan[i]  = nan;
    req_is_inf[i]  = inf;
    req_is_zero[i] = zero;
    req_sign[i]    = sgn;
    req_exp[i]     = e;
    req_man[i]     = m;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected %b", req_ready, 4'b0000); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h expected %h", res, 32'h0); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", res_id); end
    next_cycle();
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_basic();
    do_reset();
    clear_reqs();
    set_req(0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, ONE);
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_grant: got %b expected %b", req_ready, 4'b0001); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early: res_valid got %b expected 0 at cycle 1", res_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1 at cycle 2", res_valid); end
    checks++; if (res !== 32'h3F800000) begin errors++; $display("FAIL basic_res: got %h expected %h", res, 32'h3F800000); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL basic_id: got %0d expected 0", res_id); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: res_valid got %b expected 0", res_valid); end
  endtask

  task automatic test_special();
    do_reset();
    clear_reqs();
    set_req(2, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0, 46'd0);
    set_req(1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd200, ONE);
    req_valid = 4'b0110;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL special_grant1: got %b expected %b", req_ready, 4'b0010); end
    next_cycle();
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL special_grant2: got %b expected %b", req_ready, 4'b0100); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL special_valid1: got %b expected 1", res_valid); end
    checks++; if (res !== 32'h7F800000) begin errors++; $display("FAIL special_overflow: got %h expected %h", res, 32'h7F800000); end
    checks++; if (res_id !== 2'd1) begin errors++; $display("FAIL special_id1: got %0d expected 1", res_id); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL special_valid2: got %b expected 1", res_valid); end
    checks++; if (res !== 32'hFFC00000) begin errors++; $display("FAIL special_nan: got %h expected %h", res, 32'hFFC00000); end
    checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL special_id2: got %0d expected 2", res_id); end
  endtask

  task automatic test_back_to_back();
    int          exp_id  [5];
    logic [31:0] exp_val [4];
    exp_val = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000};
`ifdef SVFLOAT_PACK_ARB_ROUNDROBIN_EN
    exp_id = '{0, 1, 2, 3, 0};
`else
    exp_id = '{0, 0, 0, 0, 0};
`endif
    do_reset();
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, 9'(i), ONE);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 5) begin
        checks++; if (req_ready !== 4'(1 << exp_id[c])) begin errors++; $display("FAIL b2b_grant[%0d]: got %b expected %b", c, req_ready, 4'(1 << exp_id[c])); end
      end
      if (c >= 2 && c < 7) begin
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c, res_valid); end
        checks++; if (res_id !== 2'(exp_id[c-2])) begin errors++; $display("FAIL b2b_id[%0d]: got %0d expected %0d", c, res_id, exp_id[c-2]); end
        checks++; if (res !== exp_val[exp_id[c-2]]) begin errors++; $display("FAIL b2b_res[%0d]: got %h expected %h", c, res, exp_val[exp_id[c-2]]); end
      end
      if (c == 7) begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: res_valid got %b expected 0", res_valid); end
      end
      next_cycle();
      if (c == 4) req_valid = '0;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, 9'(i), ONE);
    res_ready = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0: got %b expected %b", req_ready, 4'b0001); end
    next_cycle();
    req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant3: got %b expected %b", req_ready, 4'b1000); end
    next_cycle();
    req_valid = 4'b1111;
    // Both stages now full with the consumer stalled.
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected %b", s, req_ready, 4'b0000); end
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d]: got %b expected 1", s, res_valid); end
      checks++; if (res !== 32'h3F800000) begin errors++; $display("FAIL bp_stall_res[%0d]: got %h expected %h", s, res, 32'h3F800000); end
      checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL bp_stall_id[%0d]: got %0d expected 0", s, res_id); end
      next_cycle();
    end
    res_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_rel_valid0: got %b expected 1", res_valid); end
    checks++; if (res !== 32'h3F800000) begin errors++; $display("FAIL bp_rel_res0: got %h expected %h", res, 32'h3F800000); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL bp_rel_id0: got %0d expected 0", res_id); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_rel_valid1: got %b expected 1", res_valid); end
    checks++; if (res !== 32'h41000000) begin errors++; $display("FAIL bp_rel_res1: got %h expected %h", res, 32'h41000000); end
    checks++; if (res_id !== 2'd3) begin errors++; $display("FAIL bp_rel_id1: got %0d expected 3", res_id); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: res_valid got %b expected 0", res_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, 9'(i), ONE);
    res_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_fill1: got %b expected %b", req_ready, 4'b0010); end
    next_cycle();
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_fill2: got %b expected %b", req_ready, 4'b0100); end
    next_cycle();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rm_in_reset_ready: got %b expected %b", req_ready, 4'b0000); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_in_reset_valid: got %b expected 0", res_valid); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_flushed: res_valid got %b expected 0", res_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr_grant: got %b expected %b", req_ready, 4'b0001); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_stale: res_valid got %b expected 0", res_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rm_valid: got %b expected 1", res_valid); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL rm_id: got %0d expected 0", res_id); end
    checks++; if (res !== 32'h3F800000) begin errors++; $display("FAIL rm_res: got %h expected %h", res, 32'h3F800000); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_drain: res_valid got %b expected 0", res_valid); end
  endtask

  initial begin
    clear_reqs();
    rst_n     = 1'b0;
    res_ready = 1'b1;
    req_valid = '0;
    test_reset();
    test_basic();
    test_special();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
